mem_arbiter: RTL and testbench

- Shares one single-port memory between instruction fetch (F stage, PC address) and data access (M stage, ALU-result address and store data).
- Serialises the two requesters, holds each pipeline side with a stall until its access completes, and returns read data with a one-cycle valid pulse.
- Sits between the pipelined CPU core and the unified memory model. It replaces the separate IM/DM ports for the unified-memory build.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_MAX times in a row.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              stall_F,
   input  logic              dm_cs,
   input  logic              dm_r,
   input  logic              dm_w,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_valid,
   output logic              stall_M,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT, RESP} state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state, state_next;
   logic [3:0] starve_cnt;
   logic       dm_req;
   logic       grant_if, grant_dm, done;

   assign dm_req  = dm_cs & (dm_r | dm_w);
   assign stall_F = if_req & ~if_valid;
   assign stall_M = dm_req & ~dm_valid;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_next = state;
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (dm_req && !(if_req && starve_cnt == STARVE_LIM)) begin
               grant_dm   = 1'b1;
               state_next = DM_WAIT;
            end else if (if_req) begin
               grant_if   = 1'b1;
               state_next = IF_WAIT;
            end
         end
         IF_WAIT, DM_WAIT: begin
            if (mem_ready) begin
               done       = 1'b1;
               state_next = RESP;
            end
         end
         // The requester still shows the completed request here, so never grant.
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments with an asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= 4'd0;
      end else if (!if_req || grant_if) begin
         starve_cnt <= 4'd0;
      end else if (grant_dm && starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_rdata  <= '0;
         dm_valid  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         if (grant_if) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
         end else if (grant_dm) begin
            mem_en    <= 1'b1;
            mem_we    <= dm_w;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_w ? dm_wdata : '0;
         end else if (done) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (state == IF_WAIT) begin
               if_rdata <= mem_rdata;
               if_valid <= 1'b1;
            end else begin
               // A held mem_we marks the finishing data access as a store.
               if (!mem_we) dm_rdata <= mem_rdata;
               dm_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed literal cases, then random traffic
// compared every cycle against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;
   logic              stall_F;
   logic              dm_cs = 1'b0;
   logic              dm_r = 1'b0;
   logic              dm_w = 1'b0;
   logic [ADDR_W-1:0] dm_addr = '0;
   logic [DATA_W-1:0] dm_wdata = '0;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;
   logic              stall_M;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .stall_F(stall_F),
      .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_M(stall_M),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: sparse store, unwritten words return an address hash.
   logic [31:0] mem_store [logic [31:0]];

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   always @(posedge clk) begin
      if (mem_en && mem_we && mem_ready) mem_store[mem_addr] = mem_wdata;
      #1 mem_rdata = mem_read(mem_addr);
   end

   // Reference model: who owns the memory, whether a response slot is pending,
   // and how many data grants in a row fetch has been waiting through.
   int          owner;      // 0 none, 1 fetch, 2 data
   bit          resp_slot;
   int          streak;
   logic        e_en, e_we, e_if_valid, e_dm_valid;
   logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner = 0; resp_slot = 0; streak = 0;
         e_en = 0; e_we = 0; e_if_valid = 0; e_dm_valid = 0;
         e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0;
      end else begin
         bit dmreq, g_if, g_dm;
         dmreq = dm_cs && (dm_r || dm_w);
         g_if = 0; g_dm = 0;
         e_if_valid = 0; e_dm_valid = 0;
         if (owner != 0) begin
            if (mem_ready) begin
               if (owner == 1) begin
                  e_if_rdata = mem_read(e_addr);
                  e_if_valid = 1;
               end else begin
                  if (!e_we) e_dm_rdata = mem_read(e_addr);
                  e_dm_valid = 1;
               end
               e_en = 0; e_we = 0; owner = 0; resp_slot = 1;
            end
         end else if (resp_slot) begin
            resp_slot = 0;
         end else if (dmreq && !(if_req && streak >= STARVE_MAX)) begin
            g_dm = 1;
         end else if (if_req) begin
            g_if = 1;
         end
         if (g_dm) begin
            owner = 2; e_en = 1; e_we = dm_w; e_addr = dm_addr;
            e_wdata = dm_w ? dm_wdata : 32'h0;
         end
         if (g_if) begin
            owner = 1; e_en = 1; e_we = 0; e_addr = if_addr; e_wdata = 0;
         end
         if (!if_req || g_if) streak = 0;
         else if (g_dm) streak = (streak < STARVE_MAX) ? streak + 1 : STARVE_MAX;
      end
   end

   always @(negedge clk) begin
      check("if_valid", if_valid, e_if_valid);
      check("dm_valid", dm_valid, e_dm_valid);
      check("if_rdata", if_rdata, e_if_rdata);
      check("dm_rdata", dm_rdata, e_dm_rdata);
      check("mem_en", mem_en, e_en);
      check("mem_we", mem_we, e_we);
      if (e_en) begin
         check("mem_addr", mem_addr, e_addr);
         check("mem_wdata", mem_wdata, e_wdata);
      end
      check("stall_F", stall_F, if_req & ~e_if_valid);
      check("stall_M", stall_M, (dm_cs & (dm_r | dm_w)) & ~e_dm_valid);
      check("valid_excl", if_valid & dm_valid, 1'b0);
   end

   task automatic random_phase(input int n);
      for (int c = 0; c < n; c++) begin
         int pick;
         if (!if_req || if_valid) begin
            if ($urandom_range(0, 2) != 0) begin
               if_req  = 1'b1;
               if_addr = 32'($urandom_range(0, 31)) << 2;
            end else begin
               if_req = 1'b0;
            end
         end
         if (!(dm_cs && (dm_r || dm_w)) || dm_valid) begin
            pick     = $urandom_range(0, 5);
            dm_cs    = (pick != 0);
            dm_r     = (pick == 2 || pick == 3 || pick == 5);
            dm_w     = (pick == 4 || pick == 5);
            dm_addr  = 32'($urandom_range(0, 31)) << 2;
            dm_wdata = $urandom();
         end
         mem_ready = ($urandom_range(0, 9) < 6);
         step();
      end
   endtask

   initial begin
      int n_dm, if_grants, dm_before1, dm_before2;
      logic prev_en;
      mem_store[32'h40]  = 32'h2008_0005;
      mem_store[32'h44]  = 32'h1111_2222;
      mem_store[32'h104] = 32'hCAFE_0104;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_if_valid", if_valid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      #2 reset = 1'b1;
      step();

      // Fetch only
      if_addr = 32'h40; if_req = 1'b1; mem_ready = 1'b0;
      #1;
      check("fetch_stall_c0", stall_F, 1);
      check("fetch_en_c0", mem_en, 0);
      step();
      check("fetch_en_c1", mem_en, 1);
      check("fetch_addr_c1", mem_addr, 32'h40);
      check("fetch_stall_c1", stall_F, 1);
      mem_ready = 1'b1;
      step();
      check("fetch_valid_c2", if_valid, 1);
      check("fetch_rdata_c2", if_rdata, 32'h2008_0005);
      check("fetch_stall_c2", stall_F, 0);
      check("fetch_en_c2", mem_en, 0);
      if_req = 1'b0; mem_ready = 1'b0;
      step();
      check("fetch_valid_c3", if_valid, 0);
      check("fetch_hold_c3", if_rdata, 32'h2008_0005);

      // Store with ready delayed three cycles
      dm_cs = 1'b1; dm_w = 1'b1; dm_r = 1'b0; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
      #1 check("store_stall_c0", stall_M, 1);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("store_en", mem_en, 1);
         check("store_we", mem_we, 1);
         check("store_addr", mem_addr, 32'h100);
         check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
         check("store_novalid", dm_valid, 0);
         if (i == 4) mem_ready = 1'b1;
      end
      step();
      check("store_valid", dm_valid, 1);
      check("store_rdata_kept", dm_rdata, 0);
      check("store_we_off", mem_we, 0);
      check("store_mem", mem_read(32'h100), 32'hDEAD_BEEF);
      dm_cs = 1'b0; dm_w = 1'b0; mem_ready = 1'b0;
      step();
      check("store_pulse_end", dm_valid, 0);

      // Simultaneous fetch and load: data first
      if_req = 1'b1; if_addr = 32'h44;
      dm_cs = 1'b1; dm_r = 1'b1; dm_w = 1'b0; dm_addr = 32'h100; mem_ready = 1'b1;
      step();
      check("sim_dm_addr", mem_addr, 32'h100);
      check("sim_dm_we", mem_we, 0);
      step();
      check("sim_dm_valid", dm_valid, 1);
      check("sim_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      check("sim_if_wait", if_valid, 0);
      dm_cs = 1'b0; dm_r = 1'b0;
      step();
      check("sim_idle_gap", mem_en, 0);
      step();
      check("sim_if_en", mem_en, 1);
      check("sim_if_addr", mem_addr, 32'h44);
      step();
      check("sim_if_valid", if_valid, 1);
      check("sim_if_rdata", if_rdata, 32'h1111_2222);
      check("sim_dm_quiet", dm_valid, 0);
      if_req = 1'b0; mem_ready = 1'b0;
      step();

      // Starvation: fetch held against back-to-back loads
      if_req = 1'b1; if_addr = 32'h48;
      dm_cs = 1'b1; dm_r = 1'b1; dm_addr = 32'h200; mem_ready = 1'b1;
      prev_en = 1'b0; n_dm = 0; if_grants = 0; dm_before1 = -1; dm_before2 = -1;
      for (int c = 0; c < 80 && if_grants < 2; c++) begin
         step();
         if (mem_en && !prev_en) begin
            if (mem_addr == 32'h48) begin
               if_grants++;
               if (if_grants == 1) dm_before1 = n_dm;
               else dm_before2 = n_dm;
               n_dm = 0;
            end else begin
               n_dm++;
            end
         end
         prev_en = mem_en;
         if (dm_valid) dm_addr = dm_addr + 32'h4;
      end
      check("starve_if_grants", if_grants, 2);
      check("starve_dm_first", dm_before1, STARVE_MAX);
      check("starve_dm_after", dm_before2, STARVE_MAX);
      if_req = 1'b0; dm_cs = 1'b0; dm_r = 1'b0;
      repeat (4) step();

      // Reset during a data access
      dm_cs = 1'b1; dm_r = 1'b1; dm_addr = 32'h104; mem_ready = 1'b0;
      step();
      check("rstmid_en_c1", mem_en, 1);
      step();
      #2 reset = 1'b0;
      #1;
      check("rstmid_en_async", mem_en, 0);
      check("rstmid_addr", mem_addr, 0);
      check("rstmid_novalid", dm_valid, 0);
      step();
      check("rstmid_held_en", mem_en, 0);
      check("rstmid_held_valid", dm_valid, 0);
      check("rstmid_stall", stall_M, 1);
      #3 reset = 1'b1;
      step();
      check("rstmid_regrant", mem_en, 1);
      check("rstmid_regrant_addr", mem_addr, 32'h104);
      mem_ready = 1'b1;
      step();
      check("rstmid_valid", dm_valid, 1);
      check("rstmid_rdata", dm_rdata, 32'hCAFE_0104);
      dm_cs = 1'b0; dm_r = 1'b0; mem_ready = 1'b0;
      step();

      // Null select is not a request
      dm_cs = 1'b1; dm_r = 1'b0; dm_w = 1'b0; if_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("null_en", mem_en, 0);
         check("null_stall", stall_M, 0);
      end
      dm_cs = 1'b0;
      step();

      random_phase(3000);

      if_req = 1'b0; dm_cs = 1'b0; dm_r = 1'b0; dm_w = 1'b0; mem_ready = 1'b1;
      repeat (6) step();
      @(posedge clk);
      #2;
      check("drain_idle", mem_en, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
